// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
// State encodings and the register-number width.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HOLD    = 2'd1,
    IRQ_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_match.sv
// Register-number compare; $0 is hardwired and never matches.
// One instance per producer/consumer pair.
module hazard_match
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] a_i,
  input  logic [REG_W-1:0] b_i,
  output logic             hit_o
);

  assign hit_o = (a_i == b_i) && (a_i != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch-operand hazard, MEM->ID forwarding and IRQ accept.
// Define HAZARD_STATS_EN to add the 32-bit stall_count output.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_Branch,
  input  logic             ID_Jump,
  input  logic             ID_JumpReg,
  input  logic             ID_Taken,
  input  logic             EX_RegWr,
  input  logic             EX_MemRd,
  input  logic [REG_W-1:0] EX_WrReg,
  input  logic             MEM_RegWr,
  input  logic             MEM_MemRd,
  input  logic [REG_W-1:0] MEM_WrReg,
  input  logic             IRQ,
  output logic             PC_hold,
  output logic             IFID_hold,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             ForwardC,
  output logic             ForwardD,
  output logic             IRQ_take,
  output logic [1:0]       state
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_count
`endif
);

  state_t state_q, state_d;
  logic   irq_s1_q, irq_s2_q;
  logic   pend_q, pend_d;

  logic ex_rs, ex_rt, mem_rs, mem_rt;
  logic use_br, ex_hit, mem_hit;
  logic hz1, hz2, br_req;
  logic stall, take, fl_ifid;

  hazard_match u_ex_rs (
    .a_i  (EX_WrReg),
    .b_i  (ID_rs),
    .hit_o(ex_rs)
  );

  hazard_match u_ex_rt (
    .a_i  (EX_WrReg),
    .b_i  (ID_rt),
    .hit_o(ex_rt)
  );

  hazard_match u_mem_rs (
    .a_i  (MEM_WrReg),
    .b_i  (ID_rs),
    .hit_o(mem_rs)
  );

  hazard_match u_mem_rt (
    .a_i  (MEM_WrReg),
    .b_i  (ID_rt),
    .hit_o(mem_rt)
  );

  assign use_br  = ID_Branch | ID_JumpReg;
  assign ex_hit  = ex_rs | ex_rt;
  assign mem_hit = mem_rs | mem_rt;
  assign br_req  = ID_Jump | (ID_Branch & ID_Taken);

  // Load feeding a branch needs two bubbles; everything else one.
  assign hz2 = use_br & EX_MemRd & ex_hit;
  assign hz1 = (EX_MemRd & ex_hit & ~use_br)
             | (use_br & EX_RegWr & ~EX_MemRd & ex_hit)
             | (use_br & MEM_MemRd & mem_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      irq_s1_q <= 1'b0;
      irq_s2_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_s1_q <= IRQ;
      irq_s2_q <= irq_s1_q;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (hz2)       state_d = HOLD;
        else if (take) state_d = IRQ_ACK;
      end
      HOLD:    state_d = RUN;
      IRQ_ACK: state_d = RUN;
      default: state_d = RUN;
    endcase
    // A second edge while pending folds into the same acceptance.
    pend_d = take ? 1'b0 : (pend_q | (irq_s1_q & ~irq_s2_q));
  end

  always_comb begin
    stall      = 1'b0;
    fl_ifid    = 1'b0;
    take       = 1'b0;
    PC_hold    = 1'b0;
    IFID_hold  = 1'b0;
    IFID_flush = 1'b0;
    IDEX_flush = 1'b0;
    ForwardC   = 1'b0;
    ForwardD   = 1'b0;
    IRQ_take   = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN:     stall = hz1 | hz2;
        HOLD:    stall = 1'b1;
        IRQ_ACK: stall = 1'b0;
        default: stall = 1'b0;
      endcase
      fl_ifid = (state_q == IRQ_ACK)
              | (br_req & ~stall);
      take = (state_q == RUN) & pend_q
           & ~stall & ~fl_ifid;
      PC_hold    = stall;
      IFID_hold  = stall;
      IFID_flush = fl_ifid;
      IDEX_flush = stall | (state_q == IRQ_ACK);
      ForwardC   = ~stall & MEM_RegWr
                 & ~MEM_MemRd & mem_rs;
      ForwardD   = ~stall & MEM_RegWr
                 & ~MEM_MemRd & mem_rt;
      IRQ_take   = take;
    end
  end

  assign state = state_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + {31'd0, stall};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`endif

endmodule
